// File: rtl/nibble_seq_adder_if.sv
// Handshake bundle for nibble_seq_adder.
//   in_valid / in_ready / in_a / in_b          : operand pair, valid/ready
//   out_valid / out_ready / out_sum / out_carry_mid : 9-bit result, valid/ready
// master : the side that supplies operands and consumes results
// slave  : the sequencer itself
interface nibble_seq_adder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_sum;
  logic       out_carry_mid;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry_mid
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry_mid
  );
endinterface

// File: rtl/nibble_seq_adder.sv
// nibble_seq_adder: sequences an external combinational nibble adder to form
// an 8-bit + 8-bit = 9-bit unsigned sum. The latched operands are presented on
// nib_a/nib_b; nib_ctrl selects the low nibble (0) then the high nibble (1),
// and the low-nibble carry is folded into the high-nibble result.
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   bus (slave)       : operand and result valid/ready handshakes
//   nib_a, nib_b      : operands driven to the nibble adder
//   nib_ctrl          : nibble select to the adder
//   nib_q             : 5-bit nibble result from the adder
//   op_count          : results handed off, wraps modulo 2^CNT_W
module nibble_seq_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_seq_adder_if.slave bus,
  output logic [7:0]       nib_a,
  output logic [7:0]       nib_b,
  output logic             nib_ctrl,
  input  logic [4:0]       nib_q,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [3:0]       low_q;
  logic             carry_q;
  logic [8:0]       sum_q;
  logic             cmid_q;
  logic [CNT_W-1:0] cnt_q;

  // High nibble plus the carry out of the low nibble; 15+15+1 fits in 5 bits.
  function automatic logic [4:0] high_add(input logic [4:0] q, input logic c);
    return q + {4'b0000, c};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = LOW;
      LOW:     state_nxt = HIGH;
      HIGH:    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, nibble capture, result and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      low_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cmid_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a <= bus.in_a;
            op_b <= bus.in_b;
          end
        end
        LOW: begin
          low_q   <= nib_q[3:0];
          carry_q <= nib_q[4];
        end
        HIGH: begin
          sum_q  <= {high_add(nib_q, carry_q), low_q};
          cmid_q <= carry_q;
        end
        DONE: begin
          if (bus.out_ready) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and registers
  assign nib_a             = op_a;
  assign nib_b             = op_b;
  assign nib_ctrl          = (state == HIGH);
  assign bus.in_ready      = (state == IDLE);
  assign bus.out_valid     = (state == DONE);
  assign bus.out_sum       = sum_q;
  assign bus.out_carry_mid = cmid_q;
  assign op_count          = cnt_q;

endmodule

// File: tb/tb_nibble_seq_adder.sv
module tb_nibble_seq_adder;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic [7:0]       nib_a;
  logic [7:0]       nib_b;
  logic             nib_ctrl;
  logic [4:0]       nib_q;
  logic [CNT_W-1:0] op_count;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  nibble_seq_adder_if bus ();

  nibble_seq_adder #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .nib_a    (nib_a),
    .nib_b    (nib_b),
    .nib_ctrl (nib_ctrl),
    .nib_q    (nib_q),
    .op_count (op_count)
  );

  // External combinational nibble adder
  assign nib_q = nib_ctrl ? ({1'b0, nib_a[7:4]} + {1'b0, nib_b[7:4]})
                          : ({1'b0, nib_a[3:0]} + {1'b0, nib_b[3:0]});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic       cmid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Called #1 after the accept edge; returns edges from accept to out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 12) begin
      tick();
      n++;
    end
  endtask

  // One full operation with out_ready high; starts in IDLE.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [8:0] sum, input logic cmid);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n);
    check({name, "_latency"}, n, 3);
    check({name, "_sum"}, bus.out_sum, sum);
    check({name, "_cmid"}, bus.out_carry_mid, cmid);
    tick();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check({name, "_count"}, op_count, exp_cnt);
  endtask

  initial begin
    int n;
    logic [7:0] ra, rb;
    logic [8:0] rsum;
    logic [4:0] rlow;

    vecs[0] = '{8'h3C, 8'h25, 9'h061, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 9'h1FE, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 9'h000, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 9'h100, 1'b0};
    vecs[4] = '{8'h0F, 8'h01, 9'h010, 1'b1};
    vecs[5] = '{8'hF0, 8'h10, 9'h100, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 9'h046, 1'b0};
    vecs[7] = '{8'h9A, 8'h47, 9'h0E1, 1'b1};

    bus.in_valid = 1'b0;
    bus.in_a = 8'h00;
    bus.in_b = 8'h00;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_nib_ctrl", nib_ctrl, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_cmid", bus.out_carry_mid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_nib_a", nib_a, 0);
    rst_n = 1'b1;
    tick();

    // Nominal with nibble-level visibility
    bus.in_valid = 1'b1;
    bus.in_a = 8'h3C;
    bus.in_b = 8'h25;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("nom_low_ctrl", nib_ctrl, 0);
    check("nom_low_q", nib_q, 5'h11);
    check("nom_low_in_ready", bus.in_ready, 0);
    tick();
    check("nom_high_ctrl", nib_ctrl, 1);
    check("nom_high_q", nib_q, 5'h05);
    check("nom_high_out_valid", bus.out_valid, 0);
    tick();
    check("nom_done_valid", bus.out_valid, 1);
    check("nom_sum", bus.out_sum, 9'h061);
    check("nom_cmid", bus.out_carry_mid, 1);
    tick();
    exp_cnt = 1;
    check("nom_count", op_count, exp_cnt);
    check("nom_in_ready_after", bus.in_ready, 1);
    check("nom_sum_held", bus.out_sum, 9'h061);

    // Table-driven vectors
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cmid);

    // Backpressure with ignored stall operands
    bus.in_valid = 1'b1;
    bus.in_a = 8'h9A;
    bus.in_b = 8'h47;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("bp_latency", n, 3);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_a = 8'h11;
      bus.in_b = 8'h11;
      tick();
      check($sformatf("bp_valid%0d", i), bus.out_valid, 1);
      check($sformatf("bp_in_ready%0d", i), bus.in_ready, 0);
      check($sformatf("bp_sum%0d", i), bus.out_sum, 9'h0E1);
      check($sformatf("bp_nib_a%0d", i), nib_a, 8'h9A);
    end
    check("bp_count_stalled", op_count, exp_cnt);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check("bp_count", op_count, exp_cnt);
    check("bp_no_simul_accept", bus.in_ready, 1);
    check("bp_sum_after", bus.out_sum, 9'h0E1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_accept", bus.in_ready, 0);
    check("bp_next_nib_a", nib_a, 8'h11);
    wait_valid(n);
    check("bp_next_latency", n, 3);
    check("bp_next_sum", bus.out_sum, 9'h022);
    tick();
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    check("bp_next_count", op_count, exp_cnt);

    // Reset in HIGH abandons the operation
    do_reset();
    tick();
    bus.in_valid = 1'b1;
    bus.in_a = 8'h55;
    bus.in_b = 8'h55;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mid_in_high", nib_ctrl, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", nib_ctrl, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_sum", bus.out_sum, 0);
    check("mid_rst_count", op_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_count_after", op_count, 0);
    run_op("mid_next", 8'h80, 8'h80, 9'h100, 1'b0);

    // Back-to-back with in_valid held: 4 cycles per op, counter wraps
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_a = 8'h01;
    bus.in_b = 8'h02;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.in_valid = 1'b0;
    check("wrap_count", op_count, 1);
    check("wrap_in_ready", bus.in_ready, 1);
    check("wrap_sum", bus.out_sum, 9'h003);
    exp_cnt = 1;

    // Random operands against a+b
    for (int i = 0; i < 50; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rsum = {1'b0, ra} + {1'b0, rb};
      rlow = {1'b0, ra[3:0]} + {1'b0, rb[3:0]};
      run_op($sformatf("rnd%0d", i), ra, rb, rsum, rlow[4]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/nibble_seq_adder.md
Name: nibble_seq_adder

Overview:
Sequencer that drives the existing combinational nibble adder from the other side of its interface. It presents latched 8-bit operands on the adder's A/B inputs and steps its ctrl select: low nibble first, then high. It reads the 5-bit nibble result back each step and propagates the low-nibble carry into the high nibble. It returns the full 9-bit sum over a valid/ready handshake.
External adder contract: ctrl=0 gives q = A[3:0]+B[3:0]; ctrl=1 gives q = A[7:4]+B[7:4]; the path is purely combinational and settles within one clock.

Parameters:
CNT_W, 8, width of completed-operation counter op_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; one clock; asynchronous, active-low
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  8  operand A
in_b  input  8  operand B
nib_a  output  8  to nibble adder A
nib_b  output  8  to nibble adder B
nib_ctrl  output  1  to nibble adder ctrl (0 = low nibble, 1 = high nibble)
nib_q  input  5  from nibble adder q
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  9  in_a + in_b, unsigned
out_carry_mid  output  1  carry out of the low nibble (nib_q[4] in LOW)
op_count  output  CNT_W  number of results handed off

Behaviour:
- Reset (rst_n=0, asynchronous) sets the following, held until release:
  - state=IDLE
  - op_a, op_b, low reg, carry reg, out_sum, out_carry_mid, op_count = 0
  - nib_ctrl=0, out_valid=0, in_ready=1
- nib_a/nib_b = op_a/op_b registers, at all times.
- nib_ctrl = (state==HIGH), decoded from state.
- in_ready = (state==IDLE).
- out_valid = (state==DONE).
- FSM (all transitions on clk rising edge):
  - IDLE: if in_valid, latch in_a->op_a and in_b->op_b, go to LOW; else stay.
  - LOW: nib_ctrl=0; capture low reg <= nib_q[3:0], carry reg <= nib_q[4]; go to HIGH.
  - HIGH: nib_ctrl=1; out_sum[3:0] <= low reg, out_sum[8:4] <= nib_q + carry reg (5-bit, max 15+15+1=31, no overflow); out_carry_mid <= carry reg; go to DONE.
  - DONE: hold out_sum and out_carry_mid stable; if out_ready, op_count <= op_count+1 (wraps to 0 past 2^CNT_W-1) and go to IDLE; else stay.
- Latency: operand accept edge -> out_valid high 3 edges later. Minimum throughput 1 op per 4 cycles when out_ready is tied high.
- in_valid outside IDLE is ignored; the operands in use are not disturbed.
- out_ready outside DONE is ignored.
- No simultaneous accept in the DONE->IDLE cycle; the new op is accepted on the following edge.
- out_sum/out_carry_mid keep the last result after handoff until the next HIGH state.
- Reset mid-operation (LOW/HIGH/DONE): the operation is abandoned with no result and no op_count increment. After release, the next accepted op computes correctly.
- nib_q is sampled only in LOW and HIGH; its value in other states is don't-care.

Test Plan:
- Nominal with carry: in_a=0x3C, in_b=0x25 (60+37), out_ready=1 -> LOW sees nib_q=0x11, HIGH sees nib_q=0x05 -> out_sum=0x061 (97), out_carry_mid=1, out_valid exactly 3 edges after accept.
- Maximum: 0xFF+0xFF -> out_sum=0x1FE, out_carry_mid=1.
- Zero: 0x00+0x00 -> out_sum=0x000, out_carry_mid=0.
- Backpressure: 0x9A+0x47, hold out_ready=0 for 5 cycles and pulse in_valid with 0x11/0x11 during the stall -> out_sum=0x0E1 stable throughout, in_ready=0, stall operands ignored; result handed off when out_ready=1, op_count +1.
- Reset mid-op: assert rst_n=0 in HIGH -> all outputs immediately at reset values and op_count unchanged at 0. Then 0x80+0x80 -> out_sum=0x100, out_carry_mid=0.
- Wrap and random: CNT_W=2, 5 back-to-back ops -> op_count=1. Then 50 random operand pairs checked against a+b golden model.
